// File: rtl/lock_level_pkg.sv
// lock_level_pkg: shared widths, output-mux select codes, dial direction
// codes and the per-dial command bundle used by lock_level and lock_dial.
package lock_level_pkg;

    localparam int W     = 5;  // datapath width
    localparam int NREG  = 8;  // scratch register-file depth
    localparam int NDIAL = 3;  // number of dials / keys

    // out5 mux select encodings
    typedef enum logic [2:0] {
        SEL_C1   = 3'd0,
        SEL_C2   = 3'd1,
        SEL_C3   = 3'd2,
        SEL_K1   = 3'd3,
        SEL_K2   = 3'd4,
        SEL_K3   = 3'd5,
        SEL_DX   = 3'd6,  // D1^D2^D3
        SEL_ZERO = 3'd7
    } out_sel_e;

    // {right,left} direction encodings
    localparam logic [1:0] DIR_UP  = 2'b10;
    localparam logic [1:0] DIR_DN  = 2'b01;
    localparam logic [1:0] DIR_CAP = 2'b11;

    // Per-dial command: clear beats load; dir only matters when load is set.
    typedef struct packed {
        logic       clr;
        logic       load;
        logic [1:0] dir;
    } dial_cmd_t;

endpackage

// File: rtl/lock_dial.sv
// lock_dial: one dial of the lock. A mod-32 up/down counter (cnt) plus a
// capture register (cap) that snapshots the counter on a capture command.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   cmd    - clear / load / direction command for this edge
//   cnt    - current counter value (Cn)
//   cap    - captured dial value (Dn)
module lock_dial
    import lock_level_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  dial_cmd_t     cmd,
    output logic [W-1:0]  cnt,
    output logic [W-1:0]  cap
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] cap_q, cap_d;

    always_comb begin
        cnt_d = cnt_q;
        cap_d = cap_q;
        if (cmd.clr) begin
            cnt_d = '0;
            cap_d = '0;
        end else if (cmd.load) begin
            // Counter arithmetic is W bits wide, so wrap at 0/31 is free.
            case (cmd.dir)
                DIR_UP:  cnt_d = cnt_q + 1'b1;
                DIR_DN:  cnt_d = cnt_q - 1'b1;
                DIR_CAP: cap_d = cnt_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            cap_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            cap_q <= cap_d;
        end
    end

    assign cnt = cnt_q;
    assign cap = cap_q;

endmodule

// File: rtl/lock_level.sv
// lock_level: three-dial combination lock datapath.
// Three lock_dial instances hold the dial counters/captures, an ALU derives
// three keys from A/B/C, a final check compares captures against keys and
// registers a match mask and the unlock result. An 8x5 scratch register
// file and an output mux provide debug visibility.
// Ports:
//   CLK, RST            - clock, synchronous active-low reset
//   LOAD                - final-check strobe
//   LOAD0               - key-load enable
//   LOAD1..LOAD3        - dial update enables
//   A, B, C             - key operands
//   rightN/leftN/ENN    - dial direction bits and clear
//   WR, regSel          - register-file write enable / address
//   outSel              - out5 mux select
//   out1..out3          - captured dials D1..D3
//   out4                - register-file read at regSel
//   out5                - mux output
//   out6                - match mask {00,m3,m2,m1}
//   res                 - unlock result
module lock_level
    import lock_level_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          LOAD,
    input  logic          LOAD0,
    input  logic          LOAD1,
    input  logic          LOAD2,
    input  logic          LOAD3,
    input  logic [W-1:0]  A,
    input  logic [W-1:0]  B,
    input  logic [W-1:0]  C,
    input  logic          right1,
    input  logic          left1,
    input  logic          EN1,
    input  logic          right2,
    input  logic          left2,
    input  logic          EN2,
    input  logic          right3,
    input  logic          left3,
    input  logic          EN3,
    input  logic          WR,
    input  logic [2:0]    regSel,
    input  logic [2:0]    outSel,
    output logic [W-1:0]  out1,
    output logic [W-1:0]  out2,
    output logic [W-1:0]  out3,
    output logic [W-1:0]  out4,
    output logic [W-1:0]  out5,
    output logic [W-1:0]  out6,
    output logic          res
);

    dial_cmd_t [NDIAL-1:0]         cmd;
    logic      [NDIAL-1:0][W-1:0]  cnt;
    logic      [NDIAL-1:0][W-1:0]  cap;

    logic      [NDIAL-1:0][W-1:0]  key_q, key_d;
    logic      [NDIAL-1:0]         mask_q, mask_d;
    logic                          res_q, res_d;
    logic      [NDIAL-1:0]         match;
    logic      [NREG-1:0][W-1:0]   rf_q, rf_d;
    logic      [W-1:0]             mux_out;

    // ---------------- dials ----------------
    assign cmd[0] = '{clr: EN1, load: LOAD1, dir: {right1, left1}};
    assign cmd[1] = '{clr: EN2, load: LOAD2, dir: {right2, left2}};
    assign cmd[2] = '{clr: EN3, load: LOAD3, dir: {right3, left3}};

    for (genvar i = 0; i < NDIAL; i++) begin : g_dial
        lock_dial u_dial (
            .clk   (CLK),
            .rst_n (RST),
            .cmd   (cmd[i]),
            .cnt   (cnt[i]),
            .cap   (cap[i])
        );
    end

    // ---------------- key ALU ----------------
    always_comb begin
        key_d = key_q;
        if (LOAD0) begin
            key_d[0] = A ^ B;
            key_d[1] = B - C;
            key_d[2] = A + C;
        end
    end

    // ---------------- final check ----------------
    // Uses the registered captures/keys, so a same-edge dial or key update
    // is only seen by the next LOAD.
    always_comb begin
        for (int i = 0; i < NDIAL; i++) begin
            match[i] = (cap[i] == key_q[i]);
        end
        mask_d = mask_q;
        res_d  = res_q;
        if (LOAD) begin
            mask_d = match;
            res_d  = &match;
        end
    end

    // ---------------- output mux ----------------
    always_comb begin
        mux_out = '0;
        case (out_sel_e'(outSel))
            SEL_C1:   mux_out = cnt[0];
            SEL_C2:   mux_out = cnt[1];
            SEL_C3:   mux_out = cnt[2];
            SEL_K1:   mux_out = key_q[0];
            SEL_K2:   mux_out = key_q[1];
            SEL_K3:   mux_out = key_q[2];
            SEL_DX:   mux_out = cap[0] ^ cap[1] ^ cap[2];
            SEL_ZERO: mux_out = '0;
            default:  mux_out = '0;
        endcase
    end

    // ---------------- scratch register file ----------------
    // Writes the pre-edge mux value, so it can snapshot any debug quantity.
    always_comb begin
        rf_d = rf_q;
        if (WR) begin
            rf_d[regSel] = mux_out;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            key_q  <= '0;
            mask_q <= '0;
            res_q  <= 1'b0;
            rf_q   <= '0;
        end else begin
            key_q  <= key_d;
            mask_q <= mask_d;
            res_q  <= res_d;
            rf_q   <= rf_d;
        end
    end

    // ---------------- outputs ----------------
    assign out1 = cap[0];
    assign out2 = cap[1];
    assign out3 = cap[2];
    assign out4 = rf_q[regSel];
    assign out5 = mux_out;
    assign out6 = {{(W-NDIAL){1'b0}}, mask_q};
    assign res  = res_q;

endmodule

// File: tb/tb_lock_level.sv
module tb_lock_level;

    typedef struct {
        logic       rst_n;
        logic [2:0] ld;          // {LOAD3,LOAD2,LOAD1}
        logic [1:0] d1, d2, d3;  // {right,left}
        logic [2:0] en;          // {EN3,EN2,EN1}
        logic       ld0;
        logic [4:0] a, b, c;
        logic       load, wr;
        logic [2:0] rsel, osel;
        logic [4:0] o1, o2, o3, o4, o5, o6;
        logic       res;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST, LOAD, LOAD0, LOAD1, LOAD2, LOAD3;
    logic [4:0] A, B, C;
    logic       right1, left1, EN1, right2, left2, EN2, right3, left3, EN3;
    logic       WR;
    logic [2:0] regSel, outSel;
    logic [4:0] out1, out2, out3, out4, out5, out6;
    logic       res;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int mc[3], md[3], mk[3], mrf[8], mm[3];
    int mres;

    vec_t tbl[$];
    vec_t v;

    always #5 CLK = ~CLK;

    lock_level dut (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .LOAD0(LOAD0),
        .LOAD1(LOAD1), .LOAD2(LOAD2), .LOAD3(LOAD3),
        .A(A), .B(B), .C(C),
        .right1(right1), .left1(left1), .EN1(EN1),
        .right2(right2), .left2(left2), .EN2(EN2),
        .right3(right3), .left3(left3), .EN3(EN3),
        .WR(WR), .regSel(regSel), .outSel(outSel),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .out5(out5), .out6(out6), .res(res)
    );

    function automatic vec_t idle();
        vec_t t;
        t.rst_n = 1'b1; t.ld = '0; t.d1 = '0; t.d2 = '0; t.d3 = '0; t.en = '0;
        t.ld0 = 1'b0; t.a = '0; t.b = '0; t.c = '0; t.load = 1'b0; t.wr = 1'b0;
        t.rsel = '0; t.osel = '0;
        t.o1 = '0; t.o2 = '0; t.o3 = '0; t.o4 = '0; t.o5 = '0; t.o6 = '0;
        t.res = 1'b0;
        return t;
    endfunction

    function automatic int mux_ref(int sel);
        case (sel)
            0, 1, 2: return mc[sel];
            3, 4, 5: return mk[sel-3];
            6:       return md[0] ^ md[1] ^ md[2];
            default: return 0;
        endcase
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic apply(vec_t t);
        RST = t.rst_n;
        {LOAD3, LOAD2, LOAD1} = t.ld;
        {right1, left1} = t.d1;
        {right2, left2} = t.d2;
        {right3, left3} = t.d3;
        {EN3, EN2, EN1} = t.en;
        LOAD0 = t.ld0; A = t.a; B = t.b; C = t.c;
        LOAD = t.load; WR = t.wr; regSel = t.rsel; outSel = t.osel;
    endtask

    // One clock edge; the model advances from its pre-edge state.
    task automatic tick();
        int nc[3], nd[3], nk[3], nrf[8], nm[3];
        int nres;
        int dir[3];
        logic [2:0] ld, en;
        @(posedge CLK);
        nc = mc; nd = md; nk = mk; nrf = mrf; nm = mm; nres = mres;
        ld = {LOAD3, LOAD2, LOAD1};
        en = {EN3, EN2, EN1};
        dir[0] = int'({right1, left1});
        dir[1] = int'({right2, left2});
        dir[2] = int'({right3, left3});
        if (!RST) begin
            for (int n = 0; n < 3; n++) begin
                nc[n] = 0; nd[n] = 0; nk[n] = 0; nm[n] = 0;
            end
            for (int r = 0; r < 8; r++) nrf[r] = 0;
            nres = 0;
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (en[n]) begin
                    nc[n] = 0; nd[n] = 0;
                end else if (ld[n]) begin
                    if (dir[n] == 2)      nc[n] = (mc[n] + 1) % 32;
                    else if (dir[n] == 1) nc[n] = (mc[n] + 31) % 32;
                    else if (dir[n] == 3) nd[n] = mc[n];
                end
            end
            if (LOAD0) begin
                nk[0] = int'(A) ^ int'(B);
                nk[1] = (int'(B) - int'(C) + 32) % 32;
                nk[2] = (int'(A) + int'(C)) % 32;
            end
            if (LOAD) begin
                for (int n = 0; n < 3; n++) nm[n] = (md[n] == mk[n]) ? 1 : 0;
                nres = nm[0] & nm[1] & nm[2];
            end
            if (WR) nrf[regSel] = mux_ref(int'(outSel));
        end
        mc = nc; md = nd; mk = nk; mrf = nrf; mm = nm; mres = nres;
        #1;
    endtask

    task automatic check_model(int cyc);
        chk($sformatf("rnd%0d out1", cyc), int'(out1), md[0]);
        chk($sformatf("rnd%0d out2", cyc), int'(out2), md[1]);
        chk($sformatf("rnd%0d out3", cyc), int'(out3), md[2]);
        chk($sformatf("rnd%0d out4", cyc), int'(out4), mrf[regSel]);
        chk($sformatf("rnd%0d out5", cyc), int'(out5), mux_ref(int'(outSel)));
        chk($sformatf("rnd%0d out6", cyc), int'(out6), mm[2]*4 + mm[1]*2 + mm[0]);
        chk($sformatf("rnd%0d res", cyc), int'(res), mres);
    endtask

    initial begin
        // ---- reset with random inputs ----
        v = idle();
        v.rst_n = 1'b0; v.ld = 3'($urandom); v.d1 = 2'($urandom); v.d2 = 2'($urandom);
        v.d3 = 2'($urandom); v.en = 3'($urandom); v.ld0 = 1'b1; v.a = 5'($urandom);
        v.b = 5'($urandom); v.c = 5'($urandom); v.load = 1'b1; v.wr = 1'b1;
        v.osel = 3'($urandom);
        apply(v);
        tick();
        chk("rst out1", int'(out1), 0);
        chk("rst out2", int'(out2), 0);
        chk("rst out3", int'(out3), 0);
        chk("rst out5", int'(out5), 0);
        chk("rst out6", int'(out6), 0);
        chk("rst res", int'(res), 0);
        for (int r = 0; r < 8; r++) begin
            regSel = 3'(r);
            #1;
            chk($sformatf("rst out4[%0d]", r), int'(out4), 0);
        end

        // ---- directed vector table ----
        v = idle(); v.rst_n = 1'b0; v.ld = 3'b111; v.d1 = 2'b10; v.d2 = 2'b10; v.d3 = 2'b10;
        v.ld0 = 1'b1; v.a = 5'd1; v.b = 5'd2; v.c = 5'd3; v.load = 1'b1; v.wr = 1'b1;
        tbl.push_back(v);
        for (int i = 1; i <= 6; i++) begin
            v = idle(); v.ld = 3'b001; v.d1 = 2'b10; v.o5 = 5'(i); tbl.push_back(v);
        end
        v = idle(); v.ld = 3'b001; v.d1 = 2'b11; v.o1 = 5'd6; v.o5 = 5'd6; tbl.push_back(v);
        v = idle(); v.en = 3'b001; tbl.push_back(v);
        v = idle(); v.ld = 3'b010; v.d2 = 2'b01; v.osel = 3'd1; v.o5 = 5'd31; tbl.push_back(v);
        v = idle(); v.ld = 3'b010; v.d2 = 2'b10; v.osel = 3'd1; v.o5 = 5'd0; tbl.push_back(v);
        v = idle(); v.ld0 = 1'b1; v.a = 5'd24; v.b = 5'd30; v.c = 5'd3; v.osel = 3'd3;
        v.o5 = 5'd6; tbl.push_back(v);
        v = idle(); v.a = 5'd1; v.osel = 3'd4; v.o5 = 5'd27; tbl.push_back(v);
        v = idle(); v.a = 5'd1; v.osel = 3'd5; v.o5 = 5'd27; tbl.push_back(v);
        v = idle(); v.osel = 3'd3; v.wr = 1'b1; v.o4 = 5'd6; v.o5 = 5'd6; tbl.push_back(v);
        v = idle(); v.rsel = 3'd1; v.osel = 3'd3; v.o5 = 5'd6; tbl.push_back(v);
        v = idle(); v.osel = 3'd7; v.o4 = 5'd6; tbl.push_back(v);
        v = idle(); v.rsel = 3'd5; v.osel = 3'd6; tbl.push_back(v);

        foreach (tbl[i]) begin
            apply(tbl[i]);
            tick();
            chk($sformatf("vec%0d out1", i), int'(out1), int'(tbl[i].o1));
            chk($sformatf("vec%0d out2", i), int'(out2), int'(tbl[i].o2));
            chk($sformatf("vec%0d out3", i), int'(out3), int'(tbl[i].o3));
            chk($sformatf("vec%0d out4", i), int'(out4), int'(tbl[i].o4));
            chk($sformatf("vec%0d out5", i), int'(out5), int'(tbl[i].o5));
            chk($sformatf("vec%0d out6", i), int'(out6), int'(tbl[i].o6));
            chk($sformatf("vec%0d res", i), int'(res), int'(tbl[i].res));
        end

        // ---- unlock sequence (keys 6/27/27 from the table) ----
        v = idle(); v.ld = 3'b111; v.d1 = 2'b10; v.d2 = 2'b01; v.d3 = 2'b01;
        repeat (5) begin apply(v); tick(); end
        v = idle(); v.ld = 3'b001; v.d1 = 2'b10; apply(v); tick();
        v = idle(); v.ld = 3'b111; v.d1 = 2'b11; v.d2 = 2'b11; v.d3 = 2'b11; apply(v); tick();
        chk("unlock D1", int'(out1), 6);
        chk("unlock D2", int'(out2), 27);
        chk("unlock D3", int'(out3), 27);
        v = idle(); v.load = 1'b1; apply(v); tick();
        chk("unlock res", int'(res), 1);
        chk("unlock mask", int'(out6), 7);
        v = idle(); apply(v); tick();
        chk("hold res", int'(res), 1);
        chk("hold mask", int'(out6), 7);
        v = idle(); v.ld = 3'b100; v.d3 = 2'b01; apply(v); tick();
        v = idle(); v.ld = 3'b100; v.d3 = 2'b11; apply(v); tick();
        chk("d3 26", int'(out3), 26);
        v = idle(); v.load = 1'b1; apply(v); tick();
        chk("lock res", int'(res), 0);
        chk("lock mask", int'(out6), 3);
        // capture and check on the same edge: check sees the old D3
        v = idle(); v.ld = 3'b100; v.d3 = 2'b10; apply(v); tick();
        v = idle(); v.ld = 3'b100; v.d3 = 2'b11; v.load = 1'b1; apply(v); tick();
        chk("same-edge D3", int'(out3), 27);
        chk("same-edge res", int'(res), 0);
        chk("same-edge mask", int'(out6), 3);
        v = idle(); v.load = 1'b1; apply(v); tick();
        chk("next res", int'(res), 1);
        chk("next mask", int'(out6), 7);

        // ---- randomized against the model ----
        for (int cyc = 0; cyc < 600; cyc++) begin
            v = idle();
            v.rst_n = ($urandom_range(0, 39) != 0);
            v.ld   = 3'($urandom);
            v.d1   = 2'($urandom); v.d2 = 2'($urandom); v.d3 = 2'($urandom);
            v.en   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
            v.ld0  = ($urandom_range(0, 5) == 0);
            v.a    = 5'($urandom); v.b = 5'($urandom); v.c = 5'($urandom);
            v.load = ($urandom_range(0, 3) == 0);
            v.wr   = ($urandom_range(0, 2) == 0);
            v.rsel = 3'($urandom); v.osel = 3'($urandom);
            apply(v);
            tick();
            check_model(cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
